mu0_boot_mem: RTL

- Program memory and boot sequencer directly upstream of the MU0 CPU.
- Accepts a program image over a valid/ready word stream and zero-fills the remaining words.
- Then pulses CPU reset and serves the CPU's zero-wait-state memory bus: reads are combinational in the same cycle, writes commit at the clock edge.
- Detects CPU halt and reports the run length.

---
 rtl/mu0_boot_mem.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mu0_boot_mem.sv
// Program memory and boot sequencer for the MU0 CPU: streams in an image, zero-fills the rest,
// pulses CPU reset, then serves a zero-wait-state bus until the CPU halts.
module mu0_boot_mem #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       load_data,
  input  logic              load_last,
  output logic              cpu_rst,
  input  logic              cpu_running,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [15:0]       cpu_writedata,
  output logic [15:0]       cpu_readdata,
  output logic              halted,
  output logic              bad_access,
  output logic [31:0]       run_cycles
);

  localparam int unsigned     IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W + 1)'(MEM_WORDS - 1);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [2:0] {
    StLoad,
    StFill,
    StBoot,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic            bad_q, bad_d;
  logic            seen_q, seen_d;
  logic [31:0]     run_q, run_d;

  logic [15:0]      mem [MEM_WORDS];
  logic             in_range;
  logic [IDX_W-1:0] rd_idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [15:0]      mem_wdata;

  assign in_range = {1'b0, cpu_address} < MEM_LIMIT;
  assign rd_idx   = cpu_address[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bad_d     = bad_q;
    seen_d    = seen_q;
    run_d     = run_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q[IDX_W-1:0];
    mem_wdata = load_data;
    unique case (state_q)
      StLoad: begin
        if (load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          // A transfer into the final word is an implicit last and needs no fill.
          if (ptr_q == LAST_PTR) begin
            state_d = StBoot;
          end else if (load_last) begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        mem_we    = 1'b1;
        mem_wdata = 16'h0000;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = StBoot;
        end
      end
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        run_d = run_q + 32'd1;
        if (cpu_running) begin
          seen_d = 1'b1;
        end
        if ((cpu_read || cpu_write) && !in_range) begin
          bad_d = 1'b1;
        end
        if (cpu_write && in_range) begin
          mem_we    = 1'b1;
          mem_waddr = rd_idx;
          mem_wdata = cpu_writedata;
        end
        // Ignore a low running flag until the CPU has actually started.
        if (seen_q && !cpu_running) begin
          state_d = StDone;
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      ptr_q   <= '0;
      bad_q   <= 1'b0;
      seen_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bad_q   <= bad_d;
      seen_q  <= seen_d;
      run_q   <= run_d;
    end
  end

  // The array has no reset; load plus fill rewrites every word before the CPU runs.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign cpu_readdata = (state_q == StRun && cpu_read && in_range) ? mem[rd_idx] : 16'h0000;
  assign load_ready   = (state_q == StLoad);
  assign cpu_rst      = (state_q == StLoad) || (state_q == StFill) || (state_q == StBoot);
  assign halted       = (state_q == StDone);
  assign bad_access   = bad_q;
  assign run_cycles   = run_q;

endmodule
